// File: rtl/sync_fifo_flags.sv
// Synchronous single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a selectable first-word-fall-through read port.
module sync_fifo_flags #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 32,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 1,
  parameter int AE_LEVEL   = 1,
  parameter bit FWFT       = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Wr_enable,
  input  logic                  Read_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] PTR_ONE   = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_accept, rd_accept;

  // The wrap bit makes the plain pointer difference an exact 0..depth occupancy.
  assign count        = wr_ptr_q - rd_ptr_q;
  assign full         = (count == DEPTH_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
  assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

  always_comb begin
    wr_accept   = Wr_enable && !full;
    rd_accept   = Read_enable && !empty;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_accept) rd_ptr_d = rd_ptr_q + PTR_ONE;
    // A new error in the same cycle as clear_err must survive the clear.
    if (clear_err)               overflow_d  = 1'b0;
    if (Wr_enable && full)       overflow_d  = 1'b1;
    if (clear_err)               underflow_d = 1'b0;
    if (Read_enable && empty)    underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is never cleared; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && wr_accept) mem_q[wr_addr] <= data_in;
  end

  if (!FWFT) begin : g_reg_read
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    always_comb begin
      dout_d = dout_q;
      if (rd_accept) dout_d = mem_q[rd_addr];
    end

    always_ff @(posedge clk) begin
      if (reset) dout_q <= '0;
      else       dout_q <= dout_d;
    end

    assign data_out = dout_q;
  end else begin : g_fwft_read
    assign data_out = empty ? '0 : mem_q[rd_addr];
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench: a registered-read and an FWFT instance run in lockstep against a queue model.
module tb_sync_fifo_flags;

  logic        clk = 1'b0;
  logic        reset, wr_en, rd_en, clear_err;
  logic [31:0] data_in;

  logic [31:0] dout0, dout1;
  logic        full0, empty0, af0, ae0, ovf0, udf0;
  logic        full1, empty1, af1, ae1, ovf1, udf1;
  logic [2:0]  count0, count1;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] sbQ[$];
  logic [31:0] expDout;
  bit          expOvf, expUdf;

  always #5 clk = ~clk;

  sync_fifo_flags #(.ADDR_WIDTH(2), .DATA_WIDTH(32), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .Wr_enable(wr_en), .Read_enable(rd_en), .data_in(data_in),
    .clear_err(clear_err), .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(udf0));

  sync_fifo_flags #(.ADDR_WIDTH(2), .DATA_WIDTH(32), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .Wr_enable(wr_en), .Read_enable(rd_en), .data_in(data_in),
    .clear_err(clear_err), .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(udf1));

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic checkAll();
    int          cnt;
    logic [31:0] expFwft;
    cnt     = sbQ.size();
    expFwft = (cnt != 0) ? sbQ[0] : 32'h0;
    checkOutput("count0",  32'(count0), 32'(cnt));
    checkOutput("full0",   32'(full0),  32'(cnt == 4));
    checkOutput("empty0",  32'(empty0), 32'(cnt == 0));
    checkOutput("af0",     32'(af0),    32'(cnt >= 3));
    checkOutput("ae0",     32'(ae0),    32'(cnt <= 1));
    checkOutput("ovf0",    32'(ovf0),   32'(expOvf));
    checkOutput("udf0",    32'(udf0),   32'(expUdf));
    checkOutput("dout0",   dout0,       expDout);
    checkOutput("count1",  32'(count1), 32'(cnt));
    checkOutput("full1",   32'(full1),  32'(cnt == 4));
    checkOutput("empty1",  32'(empty1), 32'(cnt == 0));
    checkOutput("af1",     32'(af1),    32'(cnt >= 3));
    checkOutput("ae1",     32'(ae1),    32'(cnt <= 1));
    checkOutput("ovf1",    32'(ovf1),   32'(expOvf));
    checkOutput("udf1",    32'(udf1),   32'(expUdf));
    checkOutput("dout1",   dout1,       expFwft);
  endtask

  task automatic doReset(input logic wr, input logic rd);
    reset = 1'b1; wr_en = wr; rd_en = rd; clear_err = 1'b0; data_in = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    sbQ.delete();
    expDout = 32'h0;
    expOvf  = 1'b0;
    expUdf  = 1'b0;
    checkAll();
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input logic clr, input logic [31:0] din);
    bit fullM, emptyM, wrAcc, rdAcc;
    wr_en = wr; rd_en = rd; clear_err = clr; data_in = din;
    fullM  = (sbQ.size() == 4);
    emptyM = (sbQ.size() == 0);
    wrAcc  = wr && !fullM;
    rdAcc  = rd && !emptyM;
    @(posedge clk); #1;
    if (rdAcc) expDout = sbQ.pop_front();
    if (wrAcc) sbQ.push_back(din);
    if (wr && fullM)  expOvf = 1'b1; else if (clr) expOvf = 1'b0;
    if (rd && emptyM) expUdf = 1'b1; else if (clr) expUdf = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; clear_err = 1'b0;
    checkAll();
  endtask

  initial begin
    doReset(1'b1, 1'b1);
    applyStimulus(0, 0, 0, 32'h0);

    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 32'hA0 + i);
    applyStimulus(1, 0, 0, 32'hA4);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 32'h0);
    applyStimulus(0, 1, 0, 32'h0);
    applyStimulus(0, 0, 1, 32'h0);

    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 32'h10 + i);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 32'h0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 32'hB0 + i);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 32'h0);

    for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 32'hD0 + i);
    for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0, 32'hD2 + i);
    for (int i = 0; i < 2; i++) applyStimulus(0, 1, 0, 32'h0);

    applyStimulus(1, 1, 0, 32'hE0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 32'hE1 + i);
    applyStimulus(1, 1, 0, 32'hE4);
    applyStimulus(0, 0, 1, 32'h0);
    applyStimulus(1, 0, 0, 32'hE5);
    applyStimulus(1, 0, 1, 32'hE6);
    applyStimulus(0, 0, 1, 32'h0);

    applyStimulus(0, 1, 0, 32'h0);
    doReset(1'b1, 1'b1);
    applyStimulus(1, 0, 0, 32'hC0);
    applyStimulus(0, 0, 0, 32'h0);
    applyStimulus(0, 1, 0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      if (i == 150) doReset(1'b0, 1'b1);
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 7) == 0), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Parametrised synchronous single-clock FIFO: the next generation of the team's basic FIFO. It adds programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. It drops in wherever the basic FIFO is used. All existing ports keep their names and meaning.

## Interface
Parameters:
- ADDR_WIDTH, 2: depth = 2**ADDR_WIDTH entries; legal range 1..10.
- DATA_WIDTH, 32: word width in bits.
- AF_LEVEL, 2**ADDR_WIDTH-1: almost_full asserts when count >= AF_LEVEL; legal range 1..depth.
- AE_LEVEL, 1: almost_empty asserts when count <= AE_LEVEL; legal range 0..depth-1.
- FWFT, 0: 0 = registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high; dominates all other inputs.
- Wr_enable  in  1  write request.
- Read_enable  in  1  read request.
- data_in  in  DATA_WIDTH  write data.
- clear_err  in  1  clears overflow/underflow.
- data_out  out  DATA_WIDTH  read data.
- full  out  1  count == depth.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDR_WIDTH+1  current occupancy, 0..depth.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

## Operation
- Storage is a depth x DATA_WIDTH array. Write and read pointers are ADDR_WIDTH+1 bits. The low ADDR_WIDTH bits address the array; the MSB is the wrap bit.
- A write is accepted iff Wr_enable && !full. An accepted write stores data_in at wr_ptr[ADDR_WIDTH-1:0], then wr_ptr += 1 (mod 2**(ADDR_WIDTH+1)).
- A read is accepted iff Read_enable && !empty. An accepted read does rd_ptr += 1.
- Acceptance uses only the registered state at the edge. There is no write-through-when-full and no read-through-when-empty.
  - Empty with both requests: only the write is accepted; underflow sets.
  - Full with both requests: only the read is accepted; overflow sets.
  - Neither full nor empty with both requests: both are accepted and count is unchanged.
- count = wr_ptr - rd_ptr, width ADDR_WIDTH+1.
- full, empty, almost_full and almost_empty are all decoded from the registered count. They are mutually consistent every cycle. full && empty never holds.
- Wrap-around: the pointer low bits roll from depth-1 to 0. Each pointer advances by exactly 1 per accepted operation, including at rollover; the wrap bit toggles.
- Read data, FWFT=0: data_out is a register loaded with mem[rd_ptr] on an accepted read, and holds its value otherwise.
- Read data, FWFT=1: data_out = mem[rd_ptr] combinationally while !empty, and 0 while empty.
- Error flags:
  - overflow sets on Wr_enable && full; underflow sets on Read_enable && empty.
  - Both clear on clear_err.
  - If a set condition and clear_err occur in the same cycle, set wins.
- On reset, regardless of other inputs:
  - Pointers and count go to 0.
  - empty=1, almost_empty=1, full=0, almost_full=0.
  - data_out=0, overflow=0, underflow=0.
  - Array contents are not cleared.
- Reset mid-operation discards all queued data. Requests in the reset cycle are ignored and do not set error flags.

## Timing
- All outputs are registered state or decodes of registered state. None depend combinationally on Wr_enable, Read_enable or data_in.
- Write accepted at edge N: count, empty, almost_* and full update after edge N.
- FWFT=0: read accepted at edge N gives its data on data_out after edge N (1-cycle latency); flags update at the same time.
- FWFT=1: a word written at edge N into an empty FIFO appears on data_out after edge N. An accepted read at edge N presents the next entry (or 0) after edge N.
- Error flags are visible the cycle after the offending request.
- Throughput: one write and one read per cycle, sustained.

## Test plan
Use ADDR_WIDTH=2, DATA_WIDTH=32, AF_LEVEL=3, AE_LEVEL=1 unless noted.
1. Reset, then idle:
   - empty=1, almost_empty=1, full=0, almost_full=0, count=0, data_out=0, overflow=0, underflow=0.
2. FWFT=0. Write 0xA0,0xA1,0xA2,0xA3 on consecutive cycles:
   - count goes 1,2,3,4; almost_empty drops after count=2; almost_full rises at count=3; full rises at count=4.
   - A 5th write of 0xA4 leaves count=4 and sets overflow.
   - Four reads give 0xA0..0xA3, each one cycle after its accepted read edge, then empty=1.
3. Wrap-around:
   - Write 3, read 3, then write 0xB0..0xB3: full=1, count=4.
   - Reads return 0xB0..0xB3 in order; wr_ptr wrap bit toggled.
4. Simultaneous operation:
   - At count=2, assert both requests for 10 cycles with incrementing data: count stays 2; data is read out in order.
   - At empty with both: count goes to 1 and underflow sets.
   - At full with both: count goes to 3 and overflow sets.
5. clear_err:
   - clear_err alone clears overflow/underflow the next cycle.
   - clear_err together with Wr_enable while full leaves overflow=1.
6. FWFT=1:
   - Write 0xC0 into empty: data_out=0xC0 the next cycle with no read.
   - Read: data_out=0 and empty=1.
   - Reset with 3 entries queued: count=0 and data_out=0 the next cycle.
